pong_sprite_renderer: RTL and testbench
=======================================

// Module: pong_sprite_renderer
// PURPOSE
//  Downstream of the game-logic block. Consumes the ball (square) and paddle top-left coordinates
//  plus the VGA timing generator's counters. Produces registered 12-bit RGB and matching delayed syncs.
//  Sprite coordinates are captured once per frame into shadow registers, so a frame never tears.
//  Draws background, centre dashed net, both paddles and the ball.
// PARAMETERS
//  h_video     640   active pixels per line
//  v_video     480   active lines per frame
//  sq_width    16    ball side length (px)
//  pdl_width   12    paddle thickness (px)
//  pdl_height  96    paddle height (px)
//  net_width   4     centre net width (px), columns h_video/2-2 .. h_video/2+1
//  net_dash    16    net dash period/2 in lines (dash on while (v_count/net_dash) even)
//  fg_colour   12'hFFF  sprite/net colour
//  bg_colour   12'h000  background colour
// PORTS
//  clk_0       in   1   25 MHz pixel clock
//  rst         in   1   synchronous, active-low reset
//  h_count     in   10  current pixel column from VGA timing (0..799)
//  v_count     in   10  current line from VGA timing (0..524)
//  video_on    in   1   1 = active video region
//  hsync_in    in   1   hsync from timing gen (active low)
//  vsync_in    in   1   vsync from timing gen (active low)
//  sq_xpos     in   10  ball top-left x
//  sq_ypos     in   10  ball top-left y
//  pdl1_xpos   in   10  left paddle top-left x
//  pdl1_ypos   in   10  left paddle top-left y
//  pdl2_xpos   in   10  right paddle top-left x
//  pdl2_ypos   in   10  right paddle top-left y
//  rgb         out  12  {R[3:0],G[3:0],B[3:0]}, registered
//  hsync_out   out  1   hsync_in delayed 2 cycles
//  vsync_out   out  1   vsync_in delayed 2 cycles
// BEHAVIOUR
//  - Reset (rst=0 at clk_0 edge): rgb=0, hsync_out=1, vsync_out=1, pipeline valid/hit regs=0.
//    Shadow regs load defaults: ball (320,240), pdl1 (24,191), pdl2 (603,191).
//  - Frame capture: in the cycle where h_count==0 && v_count==v_video (first blanking line),
//    all six shadow regs load the live inputs. They hold at all other times.
//    The live inputs may change freely mid-frame without visual effect.
//  - Hit test (stage 1, registered): obj hit = h>=x && h<x+w && v>=y && v<y+h.
//    Compute sums in 11 bits; no wrap. Positions near 1023 never alias to column 0.
//    Stage 1 also registers video_on, hsync_in and vsync_in.
//  - Net hit: h in [h_video/2-2, h_video/2+1] and ((v_count/net_dash) & 1)==0.
//  - Colour select (stage 2, registered). Priority: !video_on_d -> 12'h000; ball|pdl1|pdl2 -> fg_colour;
//    net -> fg_colour; else bg_colour. Overlapping sprites produce no error, only fg_colour.
//  - Latency: exactly 2 clk_0 cycles from (h_count,v_count,syncs) to rgb/hsync_out/vsync_out, fixed.
//  - Blanking: rgb forced 0 whenever delayed video_on=0, irrespective of sprite positions.
//  - Reset mid-frame: outputs return to reset values next edge. After release, the first 2 output
//    cycles reflect flushed zeros; capture waits for the next v_count==v_video.
// TESTING
//  1 Reset: hold rst=0 3 cycles -> rgb=0, hsync_out=vsync_out=1, shadows = defaults (check via pixel 320,240 = FFF next frame).
//  2 Latency: drive hsync_in 1->0 at cycle N -> hsync_out falls at N+2; same for vsync and video_on->rgb.
//  3 Ball edges: ball shadow (100,50), scan line v=50 -> rgb=FFF for h=100..115, 000 at h=99 and h=116; line v=66 all bg.
//  4 Tear-free: change sq_xpos 100->300 at v_count=200 -> rest of frame draws ball at 100; next frame at 300.
//  5 Net: v=0..15 h=318..321 -> FFF, h=317/322 -> 000; v=16..31 same columns -> 000.
//  6 Edge/overflow: pdl2_xpos=1020, v in paddle rows -> h=0..11 stays 000 (no wrap); video_on=0 with ball under h -> rgb 000.

Source files
------------

// File: rtl/pong_sprite_renderer.sv
// pong_sprite_renderer
// Two-stage pixel pipeline that draws the Pong playfield: background, dashed
// centre net, two paddles and a square ball. Sprite positions are sampled once
// per frame into shadow registers so a frame is always drawn from one
// consistent set of coordinates. The VGA syncs are delayed to match the
// fixed two-cycle colour latency.

module pong_sprite_renderer #(
  parameter int          H_VIDEO    = 640,
  parameter int          V_VIDEO    = 480,
  parameter int          SQ_WIDTH   = 16,
  parameter int          PDL_WIDTH  = 12,
  parameter int          PDL_HEIGHT = 96,
  parameter int          NET_WIDTH  = 4,
  parameter int          NET_DASH   = 16,
  parameter logic [11:0] FG_COLOUR  = 12'hFFF,
  parameter logic [11:0] BG_COLOUR  = 12'h000
) (
  input  logic        clk_0,
  input  logic        rst,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  sq_xpos,
  input  logic [9:0]  sq_ypos,
  input  logic [9:0]  pdl1_xpos,
  input  logic [9:0]  pdl1_ypos,
  input  logic [9:0]  pdl2_xpos,
  input  logic [9:0]  pdl2_ypos,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  // Sprite sizes widened to 11 bits so origin+size can never wrap to column 0.
  localparam logic [10:0] SQ_SIZE   = 11'(SQ_WIDTH);
  localparam logic [10:0] PDL_W     = 11'(PDL_WIDTH);
  localparam logic [10:0] PDL_H     = 11'(PDL_HEIGHT);

  // Net occupies NET_WIDTH columns centred on the screen.
  localparam logic [9:0]  NET_LO    = 10'(H_VIDEO / 2 - NET_WIDTH / 2);
  localparam logic [9:0]  NET_HI    = 10'(H_VIDEO / 2 - NET_WIDTH / 2 + NET_WIDTH - 1);
  localparam logic [9:0]  NET_DIV   = 10'(NET_DASH);
  localparam logic [9:0]  CAP_LINE  = 10'(V_VIDEO);

  // Shadow defaults loaded at reset.
  localparam logic [9:0]  SQ_X_RST   = 10'd320;
  localparam logic [9:0]  SQ_Y_RST   = 10'd240;
  localparam logic [9:0]  PDL1_X_RST = 10'd24;
  localparam logic [9:0]  PDL1_Y_RST = 10'd191;
  localparam logic [9:0]  PDL2_X_RST = 10'd603;
  localparam logic [9:0]  PDL2_Y_RST = 10'd191;

  // True when pos lies in [origin, origin+size), evaluated in 11 bits.
  function automatic logic in_span(input logic [9:0]  pos,
                                   input logic [9:0]  origin,
                                   input logic [10:0] size);
    logic [10:0] p;
    logic [10:0] o;
    p = {1'b0, pos};
    o = {1'b0, origin};
    return (p >= o) && (p < (o + size));
  endfunction

  // ---------------------------------------------------------------------------
  // Shadow sprite coordinates
  // ---------------------------------------------------------------------------
  logic [9:0] sq_x_q,   sq_x_d;
  logic [9:0] sq_y_q,   sq_y_d;
  logic [9:0] pdl1_x_q, pdl1_x_d;
  logic [9:0] pdl1_y_q, pdl1_y_d;
  logic [9:0] pdl2_x_q, pdl2_x_d;
  logic [9:0] pdl2_y_q, pdl2_y_d;
  logic       capture;

  // Load all six shadows together on the first blanking line, hold otherwise.
  always_comb begin
    capture  = (h_count == 10'd0) && (v_count == CAP_LINE);
    sq_x_d   = capture ? sq_xpos   : sq_x_q;
    sq_y_d   = capture ? sq_ypos   : sq_y_q;
    pdl1_x_d = capture ? pdl1_xpos : pdl1_x_q;
    pdl1_y_d = capture ? pdl1_ypos : pdl1_y_q;
    pdl2_x_d = capture ? pdl2_xpos : pdl2_x_q;
    pdl2_y_d = capture ? pdl2_ypos : pdl2_y_q;
  end

  // Shadow register bank; reset restores the centred-ball starting layout.
  // NOTE: reset is sampled on the clock edge (synchronous), so it sits inside the posedge-only block.
  always_ff @(posedge clk_0) begin
    if (!rst) begin
      sq_x_q   <= SQ_X_RST;
      sq_y_q   <= SQ_Y_RST;
      pdl1_x_q <= PDL1_X_RST;
      pdl1_y_q <= PDL1_Y_RST;
      pdl2_x_q <= PDL2_X_RST;
      pdl2_y_q <= PDL2_Y_RST;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sq_x_q   <= sq_x_d;
      sq_y_q   <= sq_y_d;
      pdl1_x_q <= pdl1_x_d;
      pdl1_y_q <= pdl1_y_d;
      pdl2_x_q <= pdl2_x_d;
      pdl2_y_q <= pdl2_y_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: hit tests against the shadow coordinates
  // ---------------------------------------------------------------------------
  logic       ball_hit_q, ball_hit_d;
  logic       pdl1_hit_q, pdl1_hit_d;
  logic       pdl2_hit_q, pdl2_hit_d;
  logic       net_hit_q,  net_hit_d;
  logic       video_on_q, video_on_d;
  logic       hsync_q,    hsync_d;
  logic       vsync_q,    vsync_d;
  logic [9:0] net_band;

  // Rectangle tests for each sprite plus the dashed net column test.
  always_comb begin
    ball_hit_d = in_span(h_count, sq_x_q, SQ_SIZE)
               && in_span(v_count, sq_y_q, SQ_SIZE);
    pdl1_hit_d = in_span(h_count, pdl1_x_q, PDL_W)
               && in_span(v_count, pdl1_y_q, PDL_H);
    pdl2_hit_d = in_span(h_count, pdl2_x_q, PDL_W)
               && in_span(v_count, pdl2_y_q, PDL_H);
    net_band   = v_count / NET_DIV;
    net_hit_d  = (h_count >= NET_LO) && (h_count <= NET_HI) && !net_band[0];
    video_on_d = video_on;
    hsync_d    = hsync_in;
    vsync_d    = vsync_in;
  end

  // Stage 1 registers; syncs idle high so reset never emits a sync pulse.
  always_ff @(posedge clk_0) begin
    if (!rst) begin
      ball_hit_q <= 1'b0;
      pdl1_hit_q <= 1'b0;
      pdl2_hit_q <= 1'b0;
      net_hit_q  <= 1'b0;
      video_on_q <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else begin
      ball_hit_q <= ball_hit_d;
      pdl1_hit_q <= pdl1_hit_d;
      pdl2_hit_q <= pdl2_hit_d;
      net_hit_q  <= net_hit_d;
      video_on_q <= video_on_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour select and sync alignment
  // ---------------------------------------------------------------------------
  logic [11:0] rgb_q,       rgb_d;
  logic        hsync_out_q, hsync_out_d;
  logic        vsync_out_q, vsync_out_d;

  // Blanking wins over everything; sprites and net share the foreground colour.
  always_comb begin
    rgb_d       = BG_COLOUR;
    hsync_out_d = hsync_q;
    vsync_out_d = vsync_q;
    if (!video_on_q) begin
      rgb_d = 12'h000;
    end else if (ball_hit_q || pdl1_hit_q || pdl2_hit_q) begin
      rgb_d = FG_COLOUR;
    end else if (net_hit_q) begin
      rgb_d = FG_COLOUR;
    end
  end

  // Output registers.
  always_ff @(posedge clk_0) begin
    if (!rst) begin
      rgb_q       <= 12'h000;
      hsync_out_q <= 1'b1;
      vsync_out_q <= 1'b1;
    end else begin
      rgb_q       <= rgb_d;
      hsync_out_q <= hsync_out_d;
      vsync_out_q <= vsync_out_d;
    end
  end

  assign rgb       = rgb_q;
  assign hsync_out = hsync_out_q;
  assign vsync_out = vsync_out_q;

endmodule

// File: tb/tb_pong_sprite_renderer.sv
// Testbench for pong_sprite_renderer: a reference pixel model pushes the
// expected {rgb,hsync,vsync} for each driven pixel into a queue; entries are
// popped and compared as the pipeline delivers them.

module tb_pong_sprite_renderer;

  logic        clk_0 = 1'b0;
  logic        rst   = 1'b0;
  logic [9:0]  h_count   = '0;
  logic [9:0]  v_count   = '0;
  logic        video_on  = 1'b0;
  logic        hsync_in  = 1'b1;
  logic        vsync_in  = 1'b1;
  logic [9:0]  sq_xpos   = '0;
  logic [9:0]  sq_ypos   = '0;
  logic [9:0]  pdl1_xpos = '0;
  logic [9:0]  pdl1_ypos = '0;
  logic [9:0]  pdl2_xpos = '0;
  logic [9:0]  pdl2_ypos = '0;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;

  pong_sprite_renderer dut (
    .clk_0     (clk_0),
    .rst       (rst),
    .h_count   (h_count),
    .v_count   (v_count),
    .video_on  (video_on),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .sq_xpos   (sq_xpos),
    .sq_ypos   (sq_ypos),
    .pdl1_xpos (pdl1_xpos),
    .pdl1_ypos (pdl1_ypos),
    .pdl2_xpos (pdl2_xpos),
    .pdl2_ypos (pdl2_ypos),
    .rgb       (rgb),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  always #20 clk_0 = ~clk_0;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } out_t;

  localparam out_t RESET_OUT = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};

  out_t  exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  string cur_test = "none";

  // Reference copy of the frame-latched sprite coordinates.
  int m_sq_x, m_sq_y, m_p1_x, m_p1_y, m_p2_x, m_p2_y;

  function automatic bit in_rect(int h, int v, int x, int y, int w, int ht);
    return (h >= x) && (h < x + w) && (v >= y) && (v < y + ht);
  endfunction

  function automatic logic [11:0] model_pixel(int h, int v, bit von);
    if (!von) return 12'h000;
    if (in_rect(h, v, m_sq_x, m_sq_y, 16, 16)) return 12'hFFF;
    if (in_rect(h, v, m_p1_x, m_p1_y, 12, 96)) return 12'hFFF;
    if (in_rect(h, v, m_p2_x, m_p2_y, 12, 96)) return 12'hFFF;
    if (h >= 318 && h <= 321 && ((v / 16) % 2) == 0) return 12'hFFF;
    return 12'h000;
  endfunction

  task automatic model_reset();
    m_sq_x = 320; m_sq_y = 240;
    m_p1_x = 24;  m_p1_y = 191;
    m_p2_x = 603; m_p2_y = 191;
  endtask

  // One pixel clock: drive on the falling edge, compare 1 ns after the rising edge.
  task automatic tick(input int h, input int v, input bit von, input bit hs, input bit vs);
    out_t got;
    out_t exp;
    @(negedge clk_0);
    h_count  = 10'(h);
    v_count  = 10'(v);
    video_on = von;
    hsync_in = hs;
    vsync_in = vs;
    if (rst) exp_q.push_back('{rgb: model_pixel(h, v, von), hs: hs, vs: vs});
    @(posedge clk_0);
    if (!rst) model_reset();
    else if (h == 0 && v == 480) begin
      m_sq_x = int'(sq_xpos);   m_sq_y = int'(sq_ypos);
      m_p1_x = int'(pdl1_xpos); m_p1_y = int'(pdl1_ypos);
      m_p2_x = int'(pdl2_xpos); m_p2_y = int'(pdl2_ypos);
    end
    #1;
    got = '{rgb: rgb, hs: hsync_out, vs: vsync_out};
    if (!rst) begin
      exp = RESET_OUT;
      exp_q.delete();
      exp_q.push_back(RESET_OUT);
    end else if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
    end else begin
      exp = RESET_OUT;
    end
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: rgb/hs/vs got %h/%b/%b expected %h/%b/%b (t=%0t)",
               cur_test, got.rgb, got.hs, got.vs, exp.rgb, exp.hs, exp.vs, $time);
    end
  endtask

  task automatic set_sprites(input int sx, input int sy, input int p1x, input int p1y,
                             input int p2x, input int p2y);
    sq_xpos   = 10'(sx);  sq_ypos   = 10'(sy);
    pdl1_xpos = 10'(p1x); pdl1_ypos = 10'(p1y);
    pdl2_xpos = 10'(p2x); pdl2_ypos = 10'(p2y);
  endtask

  task automatic capture_frame();
    tick(0, 480, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic scan_line(input int v, input int h_lo, input int h_hi);
    for (int h = h_lo; h <= h_hi; h++) tick(h, v, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    cur_test = "reset";
    rst = 1'b0;
    set_sprites(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(319, 0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick(320, 240, 1'b1, 1'b1, 1'b1);
    tick(335, 255, 1'b1, 1'b1, 1'b1);
    tick(336, 255, 1'b1, 1'b1, 1'b1);
    tick(30, 200, 1'b1, 1'b1, 1'b1);
    tick(610, 286, 1'b1, 1'b1, 1'b1);
    tick(610, 287, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_latency();
    cur_test = "latency";
    tick(10, 100, 1'b1, 1'b1, 1'b1);
    tick(11, 100, 1'b1, 1'b0, 1'b1);
    tick(12, 100, 1'b1, 1'b0, 1'b1);
    tick(13, 100, 1'b1, 1'b1, 1'b0);
    tick(14, 100, 1'b1, 1'b1, 1'b0);
    tick(15, 100, 1'b1, 1'b1, 1'b1);
    tick(319, 0, 1'b1, 1'b1, 1'b1);
    tick(319, 1, 1'b0, 1'b1, 1'b1);
    tick(319, 2, 1'b1, 1'b0, 1'b0);
    tick(319, 3, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_ball_edges();
    cur_test = "ball_edges";
    set_sprites(100, 50, 200, 300, 500, 300);
    capture_frame();
    scan_line(50, 97, 118);
    scan_line(65, 98, 117);
    scan_line(66, 97, 118);
    scan_line(49, 99, 101);
  endtask

  task automatic test_tear_free();
    cur_test = "tear_free";
    set_sprites(100, 200, 24, 300, 603, 300);
    capture_frame();
    scan_line(200, 98, 102);
    sq_xpos = 10'd300;
    scan_line(200, 103, 118);
    scan_line(205, 98, 118);
    scan_line(205, 298, 318);
    capture_frame();
    scan_line(205, 98, 118);
    scan_line(205, 298, 317);
  endtask

  task automatic test_net();
    cur_test = "net";
    set_sprites(500, 400, 20, 400, 600, 400);
    capture_frame();
    for (int v = 0; v < 32; v++) scan_line(v, 316, 323);
    scan_line(479, 316, 323);
  endtask

  task automatic test_overflow();
    cur_test = "overflow";
    set_sprites(1016, 100, 200, 300, 1020, 100);
    capture_frame();
    scan_line(150, 0, 14);
    scan_line(110, 0, 3);
    cur_test = "blank_over_ball";
    set_sprites(500, 400, 200, 300, 1020, 100);
    capture_frame();
    tick(505, 405, 1'b0, 1'b1, 1'b1);
    tick(506, 405, 1'b1, 1'b1, 1'b1);
    tick(507, 405, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midframe();
    cur_test = "reset_midframe";
    set_sprites(100, 50, 200, 300, 500, 300);
    capture_frame();
    scan_line(50, 100, 103);
    rst = 1'b0;
    tick(101, 50, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    scan_line(50, 100, 103);
    scan_line(240, 318, 337);
  endtask

  task automatic test_back_to_back();
    int h, v;
    bit von;
    cur_test = "random";
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0)
        set_sprites($urandom_range(0, 1023), $urandom_range(0, 1023),
                    $urandom_range(0, 1023), $urandom_range(0, 1023),
                    $urandom_range(0, 1023), $urandom_range(0, 1023));
      if ($urandom_range(0, 31) == 0) begin
        h = 0; v = 480;
      end else if ($urandom_range(0, 1) == 0) begin
        h = int'(m_sq_x) + $urandom_range(0, 20) - 2;
        v = int'(m_sq_y) + $urandom_range(0, 20) - 2;
        if (h < 0) h = 0;
        if (v < 0) v = 0;
        h = h % 1024;
        v = v % 1024;
      end else begin
        h = $urandom_range(0, 799);
        v = $urandom_range(0, 524);
      end
      von = (h < 640) && (v < 480);
      rst = ($urandom_range(0, 299) != 0);
      tick(h, v, von, 1'($urandom), 1'($urandom));
    end
    rst = 1'b1;
    tick(0, 0, 1'b0, 1'b1, 1'b1);
    tick(0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_ball_edges();
    test_tear_free();
    test_net();
    test_overflow();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
